// File: rtl/regfile_read_stage.sv
// ============================================================================
// regfile_read_stage
//
// Operand-read stage between decode and execute. It is the read side of a
// register file whose storage is written on the falling clock edge. The
// stage drives the file read addresses, samples operands on the rising edge
// into a one-entry output buffer, and keeps a busy-bit scoreboard of
// destination registers whose writeback has not yet arrived. Issue stalls
// until every source/destination hazard is resolved by a writeback.
//
// Ports
//   clk              clock; all state updates on the rising edge
//   reset            synchronous, active-low reset
//   in_valid         decoded instruction present
//   in_ready         stage accepts the instruction this cycle
//   in_rs1, in_rs2   source register indices
//   in_rd            destination register index
//   in_rd_we         instruction writes in_rd
//   rf_rs1_addr,
//   rf_rs2_addr      register-file read addresses (follow in_rs1/in_rs2)
//   rf_rs1_data,
//   rf_rs2_data      combinational register-file read data
//   wb_valid         writeback this cycle (file write lands on the negedge)
//   wb_addr          writeback register index
//   flush            squash the held output entry
//   out_valid        operands held for execute
//   out_ready        execute consumes the held entry
//   out_rs1_data,
//   out_rs2_data     sampled operands
//   out_rd           held destination index
//   out_rd_we        held destination write enable
//   stall_count      saturating count of hazard-stall cycles
// ============================================================================
module regfile_read_stage #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 5,
    parameter int NUM_REGS        = 32,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_WIDTH-1:0]      in_rs1,
    input  logic [ADDR_WIDTH-1:0]      in_rs2,
    input  logic [ADDR_WIDTH-1:0]      in_rd,
    input  logic                       in_rd_we,

    output logic [ADDR_WIDTH-1:0]      rf_rs1_addr,
    output logic [ADDR_WIDTH-1:0]      rf_rs2_addr,
    input  logic [DATA_WIDTH-1:0]      rf_rs1_data,
    input  logic [DATA_WIDTH-1:0]      rf_rs2_data,

    input  logic                       wb_valid,
    input  logic [ADDR_WIDTH-1:0]      wb_addr,

    input  logic                       flush,

    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_rs1_data,
    output logic [DATA_WIDTH-1:0]      out_rs2_data,
    output logic [ADDR_WIDTH-1:0]      out_rd,
    output logic                       out_rd_we,

    output logic [STALL_CNT_WIDTH-1:0] stall_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                state;
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_next;
    logic [NUM_REGS-1:0]   wb_hit;
    logic [NUM_REGS-1:0]   eff_busy;

    logic                  hazard;
    logic                  accept;
    logic                  set_rd;
    logic                  squash;
    logic                  stall_inc;
    logic                  stall_sat;

    // The file is addressed straight from decode; no registering here.
    assign rf_rs1_addr = in_rs1;
    assign rf_rs2_addr = in_rs2;

    assign out_valid = (state == FULL);

    // One-hot decode of this cycle's writeback.
    always_comb begin
        wb_hit = '0;
        if (wb_valid) begin
            wb_hit[wb_addr] = 1'b1;
        end
    end

    // A writeback landing this cycle is written on the negedge, so the new
    // value is already on rf_*_data at the next posedge: no bypass needed,
    // the busy bit is simply treated as clear.
    assign eff_busy = busy & ~wb_hit;

    // The destination term blocks WAW so that at most one write per register
    // is outstanding and a single busy bit suffices.
    assign hazard = eff_busy[in_rs1]
                  | eff_busy[in_rs2]
                  | (in_rd_we & eff_busy[in_rd]);

    // reset gates in_ready so nothing is accepted during a reset cycle.
    assign in_ready = reset && !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Writes to x0 are dropped, so they never mark anything busy.
    assign set_rd   = accept && in_rd_we && (in_rd != '0);

    // Flushing an empty stage has nothing to squash.
    assign squash   = flush && out_valid;

    assign stall_inc = in_valid && hazard && !flush;
    assign stall_sat = &stall_count;

    // Scoreboard next-state. Later assignments override earlier ones, which
    // gives the required priority: a new set beats a same-cycle clear.
    // NOTE: always_comb uses blocking '=' and assigns a default first so the
    // block is purely combinational and no latch is inferred.
    always_comb begin
        busy_next = busy;
        if (wb_valid) begin
            busy_next[wb_addr] = 1'b0;
        end
        // The squashed instruction's write will never arrive; release it.
        if (squash && out_rd_we) begin
            busy_next[out_rd] = 1'b0;
        end
        if (set_rd) begin
            busy_next[in_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the scoreboard and output buffer are ordinary flops, not
            // RAM, so they are cleared here; an entry held across reset is
            // discarded and any later writeback clears an already-clear bit.
            state        <= EMPTY;
            busy         <= '0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_rd       <= '0;
            out_rd_we    <= 1'b0;
            stall_count  <= '0;
        end else begin
            busy <= busy_next;

            if (stall_inc && !stall_sat) begin
                stall_count <= stall_count + STALL_CNT_WIDTH'(1);
            end

            // Data registers load only on accept; a flush leaves stale data
            // behind, which is harmless because out_valid drops.
            if (accept) begin
                out_rs1_data <= (in_rs1 == '0) ? '0 : rf_rs1_data;
                out_rs2_data <= (in_rs2 == '0) ? '0 : rf_rs2_data;
                out_rd       <= in_rd;
                out_rd_we    <= in_rd_we && (in_rd != '0);
            end

            case (state)
                EMPTY: begin
                    if (accept) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    // Accept while FULL already implies out_ready.
                    if (flush) begin
                        state <= EMPTY;
                    end else if (accept) begin
                        state <= FULL;
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_read_stage.sv
// ============================================================================
// tb_regfile_read_stage
//
// Bench for regfile_read_stage. The bench owns a negedge-written register
// file that answers the DUT's read addresses. A monitor pushes the expected
// operands of every accepted instruction into a queue and compares them when
// execute consumes the entry. Scripted sequences cover reset, RAW stall,
// back-pressure, flush, WAW / x0, reset while full and counter saturation.
// stall_count is built 4 bits wide so saturation is reachable quickly.
// ============================================================================
module tb_regfile_read_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rs1, in_rs2, in_rd;
    logic          in_rd_we;
    logic [AW-1:0] rf_rs1_addr, rf_rs2_addr;
    logic [DW-1:0] rf_rs1_data, rf_rs2_data;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_rs1_data, out_rs2_data;
    logic [AW-1:0] out_rd;
    logic          out_rd_we;
    logic [SW-1:0] stall_count;

    always #5 clk = ~clk;

    regfile_read_stage #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .NUM_REGS        (NR),
        .STALL_CNT_WIDTH (SW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_rd        (in_rd),
        .in_rd_we     (in_rd_we),
        .rf_rs1_addr  (rf_rs1_addr),
        .rf_rs2_addr  (rf_rs2_addr),
        .rf_rs1_data  (rf_rs1_data),
        .rf_rs2_data  (rf_rs2_data),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rs1_data (out_rs1_data),
        .out_rs2_data (out_rs2_data),
        .out_rd       (out_rd),
        .out_rd_we    (out_rd_we),
        .stall_count  (stall_count)
    );

    // Register file: x0 holds garbage so the stage's hard-zero is exercised.
    logic [DW-1:0] rf_mem [NR];
    assign rf_rs1_data = rf_mem[rf_rs1_addr];
    assign rf_rs2_data = rf_mem[rf_rs2_addr];

    always @(negedge clk) begin
        if (wb_valid && wb_addr != '0) rf_mem[wb_addr] <= wb_data;
    end

    typedef struct packed {
        logic [DW-1:0] rs1;
        logic [DW-1:0] rs2;
        logic [AW-1:0] rd;
        logic          we;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;
    exp_t sb_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_stall = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor, sampling mid-low-phase after the negedge file write.
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            sb_q.delete();
        end else begin
            if (flush && out_valid) begin
                if (sb_q.size() == 0) check("sb_flush_empty", 32'd1, 32'd0);
                else void'(sb_q.pop_front());
            end else if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_out", 32'd1, 32'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("sb_rs1", out_rs1_data, sb_e.rs1);
                    check("sb_rs2", out_rs2_data, sb_e.rs2);
                    check("sb_rd", 32'(out_rd), 32'(sb_e.rd));
                    check("sb_rd_we", 32'(out_rd_we), 32'(sb_e.we));
                end
            end
            if (in_valid && in_ready) begin
                sb_n.rs1 = (in_rs1 == '0) ? '0 : rf_mem[in_rs1];
                sb_n.rs2 = (in_rs2 == '0) ? '0 : rf_mem[in_rs2];
                sb_n.rd  = in_rd;
                sb_n.we  = in_rd_we && (in_rd != '0);
                sb_q.push_back(sb_n);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic we);
        in_valid = 1'b1;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_rd    = rd;
        in_rd_we = we;
    endtask

    logic [DW-1:0] held_rs1;

    initial begin
        for (int i = 0; i < NR; i++) rf_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
        rf_mem[0] = 32'hBAD0_BAD0;
        rf_mem[3] = 32'hDEAD_BEEF;

        reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        issue(0, 0, 0, 0);

        // Reset
        tick(); settle();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_rs1", out_rs1_data, 0);
        check("rst_rs2", out_rs2_data, 0);
        check("rst_rd", 32'(out_rd), 0);
        check("rst_rd_we", 32'(out_rd_we), 0);
        check("rst_stall", 32'(stall_count), 0);
        reset = 1'b1; in_valid = 1'b0;
        tick(); settle();
        check("idle_out_valid", 32'(out_valid), 0);
        check("idle_in_ready", 32'(in_ready), 1);

        // Basic accept with x0 on rs2
        tick();
        issue(3, 0, 1, 0); settle();
        check("t1_ready", 32'(in_ready), 1);
        tick(); in_valid = 1'b0; settle();
        check("t1_valid", 32'(out_valid), 1);
        check("t1_rs1", out_rs1_data, 32'hDEAD_BEEF);
        check("t1_rs2", out_rs2_data, 0);
        tick(); settle();
        check("t1_drain", 32'(out_valid), 0);

        // RAW stall resolved by writeback
        tick();
        issue(1, 2, 5, 1);
        tick();
        issue(5, 0, 6, 0);
        for (int k = 0; k < 3; k++) begin
            settle();
            check("raw_stall_ready", 32'(in_ready), 0);
            tick();
            exp_stall++;
        end
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
        settle();
        check("raw_stall_count", 32'(stall_count), 3);
        check("raw_wb_ready", 32'(in_ready), 1);
        tick(); wb_valid = 1'b0; in_valid = 1'b0; settle();
        check("raw_valid", 32'(out_valid), 1);
        check("raw_rs1", out_rs1_data, 32'h0000_1234);
        check("raw_stall_hold", 32'(stall_count), 32'(exp_stall));

        // Back-pressure
        tick();
        issue(10, 11, 12, 0);
        held_rs1 = rf_mem[10];
        tick();
        out_ready = 1'b0;
        issue(13, 14, 15, 0);
        for (int k = 0; k < 4; k++) begin
            settle();
            check("bp_ready", 32'(in_ready), 0);
            check("bp_valid", 32'(out_valid), 1);
            check("bp_hold_rs1", out_rs1_data, held_rs1);
            check("bp_hold_rd", 32'(out_rd), 12);
            tick();
        end
        out_ready = 1'b1; settle();
        check("bp_release_ready", 32'(in_ready), 1);
        tick(); in_valid = 1'b0; settle();
        check("bp_next_valid", 32'(out_valid), 1);
        check("bp_next_rs1", out_rs1_data, rf_mem[13]);
        check("bp_no_stall", 32'(stall_count), 32'(exp_stall));

        // Flush releases the squashed destination
        tick();
        issue(0, 0, 7, 1);
        tick();
        out_ready = 1'b0; flush = 1'b1;
        issue(7, 0, 8, 0); settle();
        check("flush_blocks", 32'(in_ready), 0);
        tick(); flush = 1'b0; out_ready = 1'b1; settle();
        check("flush_empty", 32'(out_valid), 0);
        check("flush_r7_free", 32'(in_ready), 1);
        tick(); in_valid = 1'b0; settle();
        check("flush_reader_valid", 32'(out_valid), 1);
        check("flush_reader_rs1", out_rs1_data, rf_mem[7]);
        check("flush_no_stall", 32'(stall_count), 32'(exp_stall));

        // x0 never busy, WAW stalls, same-cycle wb and set keeps busy
        tick();
        issue(0, 0, 0, 1);
        tick();
        issue(3, 3, 0, 1); settle();
        check("x0_ready", 32'(in_ready), 1);
        check("x0_we", 32'(out_rd_we), 0);
        tick();
        issue(0, 0, 9, 1);
        tick();
        issue(3, 0, 9, 1);
        for (int k = 0; k < 2; k++) begin
            settle();
            check("waw_stall", 32'(in_ready), 0);
            tick();
            exp_stall++;
        end
        wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h9999_0009; settle();
        check("waw_wb_ready", 32'(in_ready), 1);
        tick(); wb_valid = 1'b0;
        issue(9, 0, 10, 0);
        for (int k = 0; k < 2; k++) begin
            settle();
            check("wb_set_same_busy", 32'(in_ready), 0);
            tick();
            exp_stall++;
        end
        wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_9A9A; settle();
        check("r9_wb_ready", 32'(in_ready), 1);
        tick(); wb_valid = 1'b0; in_valid = 1'b0; settle();
        check("r9_rs1", out_rs1_data, 32'h0000_9A9A);
        check("waw_stall_count", 32'(stall_count), 32'(exp_stall));

        // Reset while FULL with r4 busy
        tick();
        issue(3, 0, 4, 1);
        tick(); in_valid = 1'b0; out_ready = 1'b0;
        tick(); settle();
        check("rf_full", 32'(out_valid), 1);
        check("rf_full_rs1", out_rs1_data, 32'hDEAD_BEEF);
        tick(); reset = 1'b0;
        tick(); reset = 1'b1; settle();
        check("rf_rst_valid", 32'(out_valid), 0);
        check("rf_rst_rs1", out_rs1_data, 0);
        check("rf_rst_rd", 32'(out_rd), 0);
        check("rf_rst_rd_we", 32'(out_rd_we), 0);
        check("rf_rst_stall", 32'(stall_count), 0);
        exp_stall = 0;
        tick();
        out_ready = 1'b1;
        issue(4, 0, 0, 0);
        held_rs1 = rf_mem[4];
        settle();
        check("rf_r4_ready", 32'(in_ready), 1);
        tick(); in_valid = 1'b0;
        wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h4444_4444; settle();
        check("rf_r4_valid", 32'(out_valid), 1);
        check("rf_r4_rs1", out_rs1_data, held_rs1);
        tick(); wb_valid = 1'b0;

        // Stall counter saturation
        tick();
        issue(0, 0, 20, 1);
        tick();
        issue(20, 0, 0, 0);
        for (int k = 0; k < 18; k++) tick();
        wb_valid = 1'b1; wb_addr = 5'd20; wb_data = 32'h2020_2020; settle();
        check("sat_count", 32'(stall_count), 15);
        check("sat_wb_ready", 32'(in_ready), 1);
        tick(); wb_valid = 1'b0; in_valid = 1'b0; settle();
        check("sat_rs1", out_rs1_data, 32'h2020_2020);
        check("sat_hold", 32'(stall_count), 15);
        tick();
        tick();
        tick(); settle();
        check("sb_drain", 32'(sb_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
